d1_pop_ctrl: RTL and testbench
==============================

# d1_pop_ctrl

Drain controller sitting directly downstream of the D1 FIFO in the transmission path. It issues read strobes to the FIFO, captures the FIFO's registered read data into a 2-entry output buffer, and presents it on a valid/ready interface to the next stage. Reads are issued back-to-back when space allows, for full throughput. Reads are never issued into a full buffer, and are never issued when the FIFO reports empty.

## Interface
- data_width, 6, width of FIFO words and of out_data
- cnt_width, 8, width of pop_count

- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- init  in  1  active-high run enable; low flushes buffer and in-flight read, holds rd_enable_D1 low
- empty_fifo_D1  in  1  D1 FIFO empty flag (registered count == 0)
- data_out_D1  in  data_width  D1 FIFO read data; valid the cycle after rd_enable_D1 was high
- out_ready  in  1  downstream accepts out_data this cycle
- rd_enable_D1  out  1  combinational read strobe to D1 FIFO
- out_valid  out  1  out_data holds a valid word
- out_data  out  data_width  buffer head word
- pop_count  out  cnt_width  words delivered (valid & ready), wraps modulo 2^cnt_width
- idle  out  1  high in state IDLE

## Operation
- Buffer: 2-entry FIFO with registered occupancy occ (0..2). Head drives out_data. The next word loads on the cycle after the head is consumed.
- inflight: 1-bit register, set to rd_enable_D1 every cycle. It marks a word arriving on data_out_D1 this cycle.
- pop = out_valid & out_ready.
- rd_enable_D1 = init & ~reset & ~empty_fifo_D1 & (occ + inflight - pop < 2). The sum is computed 3 bits wide, with no wrap.
- Capture: when inflight=1, data_out_D1 is written into the buffer tail on this clock edge. With pop on the same edge, occ is unchanged.
- occ update: occ + inflight - pop. The rd_enable rule guarantees occ never exceeds 2. An inflight arriving while occ==2 with no pop is an impossible state. Assertion required.
- out_valid = (occ != 0). When occ==0, out_data = 0.
- pop_count increments by 1 on each pop and wraps from 2^cnt_width-1 to 0.
- FSM, 2 states:
  - IDLE: occ==0 and inflight==0.
  - IDLE -> ACTIVE when rd_enable_D1=1.
  - ACTIVE -> IDLE when the next-cycle occ==0 and rd_enable_D1=0.
  - idle = (state==IDLE).
- init low, checked after reset:
  - occ, inflight and the buffer clear to 0, and state goes to IDLE.
  - pop_count is held.
  - A word in flight that cycle is discarded; the FIFO also flushes on init low.
- reset:
  - Has priority over init.
  - Clears everything, including pop_count.
  - Takes effect on the next edge regardless of in-flight traffic.

## Timing
- Reset values:
  - rd_enable_D1=0, out_valid=0, out_data=0, pop_count=0, idle=1.
  - Internally, occ=0 and inflight=0.
- Read latency:
  - rd_enable_D1 high in cycle N.
  - Data is on data_out_D1 in cycle N+1 and captured at the end of N+1.
  - out_valid is high from cycle N+2.
  - FIFO-to-output latency is 2 cycles.
- Throughput: 1 word/cycle while out_ready=1 and the FIFO is non-empty (steady state occ=1, inflight=1, pop=1).
- Backpressure:
  - With out_ready=0, at most 2 words are held.
  - rd_enable_D1 drops once occ + inflight reaches 2.
  - Reads resume in the same cycle that out_ready returns high.
- Empty boundary: empty_fifo_D1 reflects the FIFO count updated at the same edge as the read, so a last-word read followed by empty=1 issues no further read.
- Simultaneous capture and pop with occ=1: the head advances to the captured word, occ stays 1, and there is no bubble.
- out_data is stable while out_valid=1 and out_ready=0.

## Test plan
- Reset with FIFO preloaded with 3 words (0x11,0x22,0x33), reset=1 for 2 cycles -> during reset rd_enable_D1=0, out_valid=0, pop_count=0, idle=1; reads start the first cycle after reset falls.
- Stream 4 words, out_ready=1 constant -> rd_enable_D1 high 4 consecutive cycles; out_valid high 4 consecutive cycles starting 2 cycles after the first read; data in order; pop_count=4; idle=1 after drain.
- Backpressure: 4 words queued, out_ready=0 -> exactly 2 reads issued, occ=2, out_data=first word stable; release out_ready -> remaining words delivered in order, no loss or duplicate.
- Single-word FIFO (empty toggles after one read) -> exactly one rd_enable_D1 pulse; out_valid for one cycle with out_ready=1.
- init dropped while inflight=1 and occ=1, pop_count=5 -> next cycle out_valid=0, idle=1, pop_count=5; after init returns, new words are delivered with no stale data.
- pop_count wrap with cnt_width=8 -> 256 pops return pop_count to 0; 257th pop gives 1.

Source files
------------

// File: rtl/d1_pop_ctrl.sv
// Drain controller downstream of the D1 FIFO: issues read strobes, captures
// the registered read data into a 2-entry buffer and presents it valid/ready.
module d1_pop_ctrl #(
    parameter int unsigned data_width = 6,
    parameter int unsigned cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  empty_fifo_D1,
    input  logic [data_width-1:0] data_out_D1,
    input  logic                  out_ready,
    output logic                  rd_enable_D1,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data,
    output logic [cnt_width-1:0]  pop_count,
    output logic                  idle
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                state;
    logic [1:0]            occ;
    logic                  inflight;
    logic [data_width-1:0] buf0;
    logic [data_width-1:0] buf1;

    logic                  pop;
    logic [2:0]            fill;
    logic [1:0]            occ_next;
    logic [1:0]            occ_after_pop;
    logic [data_width-1:0] buf0_next;
    logic [data_width-1:0] buf1_next;

    // Occupancy counting the word already in flight; reads stop at 2.
    assign pop           = out_valid & out_ready;
    assign fill          = 3'(occ) + 3'(inflight) - 3'(pop);
    assign occ_next      = fill[1:0];
    assign occ_after_pop = occ - 2'(pop);
    assign rd_enable_D1  = init & ~reset & ~empty_fifo_D1 & (fill < 3'd2);

    assign out_valid = (occ != 2'd0);
    assign out_data  = out_valid ? buf0 : '0;
    assign idle      = (state == IDLE);

    // Shift on pop, then write the arriving word into the first free slot.
    always_comb begin
        buf0_next = buf0;
        buf1_next = buf1;
        if (pop) begin
            buf0_next = buf1;
            buf1_next = '0;
        end
        if (inflight) begin
            if (occ_after_pop == 2'd0) begin
                buf0_next = data_out_D1;
            end else begin
                buf1_next = data_out_D1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            occ       <= 2'd0;
            inflight  <= 1'b0;
            buf0      <= '0;
            buf1      <= '0;
            pop_count <= '0;
        end else if (!init) begin
            // Flush everything in flight; the delivered-word count survives.
            state    <= IDLE;
            occ      <= 2'd0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            occ      <= occ_next;
            inflight <= rd_enable_D1;
            buf0     <= buf0_next;
            buf1     <= buf1_next;
            if (pop) begin
                pop_count <= pop_count + cnt_width'(1);
            end
            case (state)
                IDLE:    if (rd_enable_D1) state <= ACTIVE;
                ACTIVE:  if ((occ_next == 2'd0) && !rd_enable_D1) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A word can never land in a full buffer that is not draining.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(init && inflight && (occ == 2'd2) && !pop));

endmodule

// File: tb/tb_d1_pop_ctrl.sv
// Randomized bench for d1_pop_ctrl against a queue-based model of the
// words read from the FIFO and not yet delivered.
module tb_d1_pop_ctrl;

    localparam int unsigned DW = 6;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic          empty_fifo_D1;
    logic [DW-1:0] data_out_D1;
    logic          out_ready;
    logic          rd_enable_D1;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] pop_count;
    logic          idle;

    always #5 clk = ~clk;

    d1_pop_ctrl #(.data_width(DW), .cnt_width(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .empty_fifo_D1 (empty_fifo_D1),
        .data_out_D1   (data_out_D1),
        .out_ready     (out_ready),
        .rd_enable_D1  (rd_enable_D1),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .pop_count     (pop_count),
        .idle          (idle)
    );

    typedef struct {
        logic [DW-1:0] w;
        int            rdy;
    } ent_t;

    ent_t          exp_q[$];
    logic [DW-1:0] fifo[$];
    int            cyc    = 0;
    logic [CW-1:0] pc     = '0;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo.push_back(w);
        empty_fifo_D1 = 1'b0;
    endtask

    // Check one cycle against the model, then advance the FIFO and model.
    task automatic tick();
        logic          v_exp;
        logic          p_exp;
        logic          rd_exp;
        logic          rst_s;
        logic          init_s;
        logic [DW-1:0] d_exp;
        logic [DW-1:0] w;
        #1;
        v_exp  = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
        d_exp  = v_exp ? exp_q[0].w : '0;
        p_exp  = v_exp && out_ready;
        rd_exp = !reset && init && !empty_fifo_D1 && ((exp_q.size() - int'(p_exp)) < 2);
        check("rd_enable", 32'(rd_enable_D1), 32'(rd_exp));
        check("out_valid", 32'(out_valid), 32'(v_exp));
        check("out_data", 32'(out_data), 32'(d_exp));
        check("pop_count", 32'(pop_count), 32'(pc));
        check("idle", 32'(idle), 32'(exp_q.size() == 0));
        rst_s  = reset;
        init_s = init;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            exp_q.delete();
            pc = '0;
        end else if (!init_s) begin
            exp_q.delete();
            fifo.delete();
        end else begin
            if (p_exp) begin
                void'(exp_q.pop_front());
                pc++;
            end
            if (rd_exp && (fifo.size() > 0)) begin
                w           = fifo.pop_front();
                data_out_D1 = w;
                exp_q.push_back('{w: w, rdy: cyc + 1});
            end
        end
        empty_fifo_D1 = (fifo.size() == 0);
    endtask

    initial begin
        reset         = 1'b1;
        init          = 1'b1;
        out_ready     = 1'b1;
        data_out_D1   = '0;
        empty_fifo_D1 = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with a preloaded FIFO; reads start once it falls.
        push_word(6'h11);
        push_word(6'h22);
        push_word(6'h33);
        repeat (2) tick();
        reset = 1'b0;
        repeat (8) tick();

        // Steady stream at full throughput.
        push_word(6'h01);
        push_word(6'h02);
        push_word(6'h03);
        push_word(6'h04);
        repeat (10) tick();

        // Backpressure: only two words may be held, head stays put.
        out_ready = 1'b0;
        push_word(6'h05);
        push_word(6'h06);
        push_word(6'h07);
        push_word(6'h08);
        repeat (6) tick();
        check("bp_head", 32'(out_data), 32'h05);
        check("bp_fifo_left", fifo.size(), 2);
        out_ready = 1'b1;
        repeat (10) tick();

        // Single-word FIFO.
        push_word(6'h2a);
        repeat (6) tick();

        // Drop init mid-stream once five words have been delivered.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) push_word(6'(6'h30 + i));
        for (int i = 0; i < 20 && pc != 8'd5; i++) tick();
        check("pre_init_cnt", 32'(pc), 32'd5);
        init = 1'b0;
        tick();
        check("init_drop_cnt", 32'(pop_count), 32'd5);
        check("init_drop_valid", 32'(out_valid), 32'd0);
        check("init_drop_idle", 32'(idle), 32'd1);
        init = 1'b1;
        push_word(6'h3c);
        push_word(6'h3d);
        push_word(6'h3e);
        repeat (8) tick();

        // Counter wrap: 257 pops from reset leaves pop_count at 1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 257; i++) push_word(6'($urandom));
        repeat (262) tick();
        check("wrap", 32'(pop_count), 32'd1);

        // Random traffic with occasional flushes and resets.
        for (int i = 0; i < 1500; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            init      = ($urandom_range(0, 39) != 0);
            reset     = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 2) == 0 && fifo.size() < 8) push_word(6'($urandom));
            tick();
        end
        reset     = 1'b0;
        init      = 1'b1;
        out_ready = 1'b1;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
